// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I-subset control unit sequencing fetch/decode/execute/mem/writeback
// over a shared ALU, register file and single memory port.
module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             alu_ltu,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             alu_sub,
  output logic             alu_src_imm,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              timeout_c;
  logic              set_bus_err, set_illegal;
  logic              taken;
  logic              is_r, is_i, is_load, is_store, is_branch, is_jal, is_lui;
  logic              unused_funct7;

  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_lui    = (opcode == OP_LUI);

  // Only funct7[5] distinguishes SUB/SRA from ADD/SRL.
  assign unused_funct7 = &{1'b0, funct7[6], funct7[4:0]};

  // Last permitted wait cycle of the current memory access.
  assign timeout_c = (wait_q == WAIT_W'(TIMEOUT - 1));

  // Branch decision from ALU compare flags.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = ~alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = ~alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = ~alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Wait counter restarts whenever FETCH or MEM is (re)entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q  <= '0;
      instret <= '0;
      bus_err <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM)))
        wait_q <= wait_q + WAIT_W'(1);
      else
        wait_q <= '0;
      if (pc_write)    instret <= instret + CNT_W'(1);
      if (set_bus_err) bus_err <= 1'b1;
      if (set_illegal) illegal <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_write    = 1'b0;
    alu_sub     = 1'b0;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 2'b00;
    pc_write    = 1'b0;
    pc_sel      = 1'b0;
    halted      = 1'b0;
    set_bus_err = 1'b0;
    set_illegal = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_c) begin
          set_bus_err = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_DECODE: begin
        if (is_r || is_i || is_load || is_store || is_branch || is_jal) begin
          state_d = S_EXEC;
        end else if (is_lui) begin
          state_d = S_WB;
        end else begin
          set_illegal = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_EXEC: begin
        alu_src_imm = is_i || is_load || is_store;
        alu_sub     = is_branch || (is_r && (funct7[5] || funct3[1])) || (is_i && funct3[1]);
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_write = 1'b1;
          pc_sel   = taken;
          state_d  = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_c) begin
          set_bus_err = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
        if (is_load)     wb_sel = 2'b01;
        else if (is_jal) wb_sel = 2'b10;
        else if (is_lui) wb_sel = 2'b11;
        pc_sel = is_jal;
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
